// File: rtl/vscale_lsu_if.sv
// vscale_lsu_if: groups the execute-stage request/response signals and the
// data-memory port of the load/store unit.
//
//   Request  : req_valid, req_ready, req_wen, req_size, req_unsigned,
//              req_addr, req_wdata
//   Memory   : dmem_en, dmem_wen, dmem_addr (address phase);
//              dmem_wdata, dmem_wstrb, dmem_wait, dmem_rdata,
//              dmem_badmem_e (data phase)
//   Response : resp_valid, resp_rdata, resp_fault_misaligned,
//              resp_fault_access
//
// The master modport is the LSU itself. The slave modport is the environment
// around it: the execute stage and the data memory.
interface vscale_lsu_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              dmem_en;
    logic              dmem_wen;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_wstrb;
    logic              dmem_wait;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_badmem_e;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_fault_misaligned;
    logic              resp_fault_access;

    modport master (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output dmem_en, dmem_wen, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_wait, dmem_rdata, dmem_badmem_e,
        output resp_valid, resp_rdata, resp_fault_misaligned, resp_fault_access
    );

    modport slave (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  dmem_en, dmem_wen, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_wait, dmem_rdata, dmem_badmem_e,
        input  resp_valid, resp_rdata, resp_fault_misaligned, resp_fault_access
    );
endinterface

// File: rtl/vscale_lsu.sv
// vscale_lsu: load/store unit between the execute stage and the data-memory
// port. Positions store data and byte strobes on the bus lanes, extracts and
// sign/zero-extends load data, and either splits an access that crosses an
// XLEN/8-byte boundary into two beats (ALLOW_MISALIGNED=1) or faults any
// misaligned access without touching the bus (ALLOW_MISALIGNED=0).
// One transaction outstanding; the response is a one-cycle pulse.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    vscale_lsu_if.master: request, data-memory port and response
//
// Parameters:
//   XLEN              data/address width, 32 or 64
//   ALLOW_MISALIGNED  1 = split boundary-crossing accesses, 0 = fault them
module vscale_lsu #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    vscale_lsu_if.master  bus
);
    localparam int B    = XLEN / 8;
    localparam int OFFW = $clog2(B);

    typedef enum logic [1:0] {
        S_IDLE,
        S_D0,
        S_D1,
        S_RESP
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic [OFFW-1:0] req_off;
    logic [3:0]      req_n;
    logic            req_misaligned;
    logic            req_cross;
    logic            req_illegal;
    logic            req_fault_early;

    assign req_off     = bus.req_addr[OFFW-1:0];
    assign req_n       = 4'd1 << bus.req_size;
    // n-1 as a 3-bit mask; for n=8 the low bits wrap to 0 and minus 1 gives 7.
    assign req_misaligned = (bus.req_addr[2:0] & (req_n[2:0] - 3'd1)) != 3'd0;
    assign req_cross   = (int'(req_off) + int'(req_n)) > B;
    assign req_illegal = (bus.req_size == 2'd3) && (XLEN == 32);
    // Requests that are answered without any bus activity.
    assign req_fault_early = req_illegal || (req_misaligned && !ALLOW_MISALIGNED);

    // ------------------------------------------------------------------
    // Latched request and beat results
    // ------------------------------------------------------------------
    logic            r_wen;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [OFFW-1:0] r_off;
    logic            r_cross;
    logic [XLEN-1:0] r_base;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_hi;
    logic            r_fault_access;
    logic            r_fault_misaligned;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen              <= 1'b0;
            r_size             <= 2'd0;
            r_unsigned         <= 1'b0;
            r_off              <= '0;
            r_cross            <= 1'b0;
            r_base             <= '0;
            r_wdata            <= '0;
            r_lo               <= '0;
            r_hi               <= '0;
            r_fault_access     <= 1'b0;
            r_fault_misaligned <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_wen              <= bus.req_wen;
                        r_size             <= bus.req_size;
                        r_unsigned         <= bus.req_unsigned;
                        r_off              <= req_off;
                        r_cross            <= req_cross;
                        r_base             <= bus.req_addr & ~XLEN'(B - 1);
                        r_wdata            <= bus.req_wdata;
                        r_lo               <= '0;
                        // hi stays 0 for single-beat accesses so the merge
                        // shifts in zeros.
                        r_hi               <= '0;
                        r_fault_access     <= req_illegal;
                        r_fault_misaligned <= !req_illegal && req_misaligned
                                              && !ALLOW_MISALIGNED;
                    end
                end
                S_D0: begin
                    if (!bus.dmem_wait) begin
                        r_lo           <= bus.dmem_rdata;
                        r_fault_access <= bus.dmem_badmem_e;
                    end
                end
                S_D1: begin
                    if (!bus.dmem_wait) begin
                        r_hi           <= bus.dmem_rdata;
                        r_fault_access <= r_fault_access | bus.dmem_badmem_e;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store lane positioning over two beats' worth of lanes
    // ------------------------------------------------------------------
    logic [3:0]        r_n;
    logic [2*XLEN-1:0] wdata2;
    logic [2*B-1:0]    strb_base;
    logic [2*B-1:0]    strb2;

    assign r_n    = 4'd1 << r_size;
    assign wdata2 = {{XLEN{1'b0}}, r_wdata} << {r_off, 3'b000};

    // NOTE: every variable written in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        strb_base = '0;
        for (int i = 0; i < 2 * B; i++) begin
            strb_base[i] = (i < int'(r_n));
        end
    end

    assign strb2 = strb_base << r_off;

    // ------------------------------------------------------------------
    // Load merge and extension
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   load_mask;
    logic              load_sign;
    logic [XLEN-1:0]   load_ext;

    assign merged = {r_hi, r_lo} >> {r_off, 3'b000};

    always_comb begin
        load_mask = '0;
        for (int i = 0; i < B; i++) begin
            load_mask[8*i +: 8] = (i < int'(r_n)) ? 8'hFF : 8'h00;
        end
        load_sign = merged[8 * int'(r_n) - 1];
        load_ext  = merged[XLEN-1:0] & load_mask;
        if (load_sign && !r_unsigned) begin
            load_ext = load_ext | ~load_mask;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_next = req_fault_early ? S_RESP : S_D0;
                end
            end
            S_D0: begin
                if (!bus.dmem_wait) begin
                    if (bus.dmem_badmem_e || !r_cross) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_D1;
                    end
                end
            end
            S_D1: begin
                if (!bus.dmem_wait) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.req_ready             = 1'b0;
        bus.dmem_en               = 1'b0;
        bus.dmem_wen              = 1'b0;
        bus.dmem_addr             = '0;
        bus.dmem_wdata            = '0;
        bus.dmem_wstrb            = '0;
        bus.resp_valid            = 1'b0;
        bus.resp_rdata            = '0;
        bus.resp_fault_misaligned = 1'b0;
        bus.resp_fault_access     = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid && !req_fault_early) begin
                    bus.dmem_en   = 1'b1;
                    bus.dmem_wen  = bus.req_wen;
                    bus.dmem_addr = bus.req_addr & ~XLEN'(B - 1);
                end
            end
            S_D0: begin
                bus.dmem_wdata = wdata2[XLEN-1:0];
                bus.dmem_wstrb = strb2[B-1:0];
                // Beat 1's address phase overlaps beat 0's final data cycle.
                if (!bus.dmem_wait && !bus.dmem_badmem_e && r_cross) begin
                    bus.dmem_en   = 1'b1;
                    bus.dmem_wen  = r_wen;
                    bus.dmem_addr = r_base + XLEN'(B);
                end
            end
            S_D1: begin
                bus.dmem_wdata = wdata2[2*XLEN-1:XLEN];
                bus.dmem_wstrb = strb2[2*B-1:B];
            end
            S_RESP: begin
                bus.resp_valid            = 1'b1;
                bus.resp_fault_misaligned = r_fault_misaligned;
                bus.resp_fault_access     = r_fault_access;
                // Stores and faulted accesses never return data.
                if (!r_wen && !r_fault_access && !r_fault_misaligned) begin
                    bus.resp_rdata = load_ext;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_vscale_lsu.sv
// tb_vscale_lsu: directed bench for vscale_lsu at XLEN=32. u_dut1 splits
// boundary-crossing accesses, u_dut0 faults misaligned ones. Inputs change on
// the falling edge and outputs are sampled 1 time unit later.
module tb_vscale_lsu;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    vscale_lsu_if #(.XLEN(32)) b1 ();
    vscale_lsu_if #(.XLEN(32)) b0 ();

    vscale_lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.master)
    );

    vscale_lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.master)
    );

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        split;
        logic [31:0] exp;
    } load_vec_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        split;
        logic [3:0]  s0;
        logic [31:0] w0;
        logic [3:0]  s1;
        logic [31:0] w1;
    } store_vec_t;

    task automatic req1(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        b1.req_valid    = 1'b1;
        b1.req_wen      = wen;
        b1.req_size     = size;
        b1.req_unsigned = uns;
        b1.req_addr     = addr;
        b1.req_wdata    = wdata;
    endtask

    task automatic test_reset();
        total++; if (b1.req_ready !== 1'b1) $display("FAIL reset_ready1: got %b want 1", b1.req_ready); else passed++;
        total++; if (b0.req_ready !== 1'b1) $display("FAIL reset_ready0: got %b want 1", b0.req_ready); else passed++;
        total++; if (b1.dmem_en !== 1'b0) $display("FAIL reset_en: got %b want 0", b1.dmem_en); else passed++;
        total++; if (b1.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", b1.resp_valid); else passed++;
        total++; if (b1.resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", b1.resp_rdata); else passed++;
    endtask

    task automatic test_loads();
        load_vec_t lv [10];
        lv[0] = '{2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF};
        lv[1] = '{2'd0, 1'b0, 32'h0000_0103, 32'h8000_0000, 32'h0, 1'b0, 32'hFFFF_FF80};
        lv[2] = '{2'd0, 1'b1, 32'h0000_0103, 32'h8000_0000, 32'h0, 1'b0, 32'h0000_0080};
        lv[3] = '{2'd1, 1'b0, 32'h0000_0102, 32'h8001_0000, 32'h0, 1'b0, 32'hFFFF_8001};
        lv[4] = '{2'd1, 1'b1, 32'h0000_0102, 32'h8001_0000, 32'h0, 1'b0, 32'h0000_8001};
        lv[5] = '{2'd2, 1'b0, 32'h0000_0103, 32'h1122_3344, 32'h5566_7788, 1'b1, 32'h6677_8811};
        lv[6] = '{2'd1, 1'b0, 32'h0000_0103, 32'hAB00_0000, 32'h0000_00CD, 1'b1, 32'hFFFF_CDAB};
        lv[7] = '{2'd0, 1'b0, 32'h0000_0101, 32'h0000_7F00, 32'h0, 1'b0, 32'h0000_007F};
        lv[8] = '{2'd2, 1'b0, 32'h0000_00FE, 32'h1122_3344, 32'h5566_7788, 1'b1, 32'h7788_1122};
        lv[9] = '{2'd1, 1'b0, 32'h0000_0101, 32'h007F_FE00, 32'h0, 1'b0, 32'h0000_7FFE};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req1(1'b0, lv[i].size, lv[i].uns, lv[i].addr, 32'h0);
            #1;
            total++; if (b1.dmem_en !== 1'b1) $display("FAIL load%0d_en0: got %b want 1", i, b1.dmem_en); else passed++;
            total++; if (b1.dmem_wen !== 1'b0) $display("FAIL load%0d_wen: got %b want 0", i, b1.dmem_wen); else passed++;
            total++; if (b1.dmem_addr !== (lv[i].addr & 32'hFFFF_FFFC)) $display("FAIL load%0d_addr0: got %h want %h", i, b1.dmem_addr, lv[i].addr & 32'hFFFF_FFFC); else passed++;
            @(negedge clk);
            b1.req_valid  = 1'b0;
            b1.dmem_rdata = lv[i].d0;
            #1;
            total++; if (b1.resp_valid !== 1'b0) $display("FAIL load%0d_early_resp: got %b want 0", i, b1.resp_valid); else passed++;
            total++; if (b1.dmem_en !== lv[i].split) $display("FAIL load%0d_en1: got %b want %b", i, b1.dmem_en, lv[i].split); else passed++;
            if (lv[i].split) begin
                total++; if (b1.dmem_addr !== (lv[i].addr & 32'hFFFF_FFFC) + 32'd4) $display("FAIL load%0d_addr1: got %h want %h", i, b1.dmem_addr, (lv[i].addr & 32'hFFFF_FFFC) + 32'd4); else passed++;
                @(negedge clk);
                b1.dmem_rdata = lv[i].d1;
                #1;
                total++; if (b1.resp_valid !== 1'b0) $display("FAIL load%0d_split_early_resp: got %b want 0", i, b1.resp_valid); else passed++;
            end
            @(negedge clk);
            b1.dmem_rdata = 32'h0;
            #1;
            total++; if (b1.resp_valid !== 1'b1) $display("FAIL load%0d_resp_valid: got %b want 1", i, b1.resp_valid); else passed++;
            total++; if (b1.resp_rdata !== lv[i].exp) $display("FAIL load%0d_rdata: got %h want %h", i, b1.resp_rdata, lv[i].exp); else passed++;
            total++; if ({b1.resp_fault_misaligned, b1.resp_fault_access} !== 2'b00) $display("FAIL load%0d_faults: got %b want 00", i, {b1.resp_fault_misaligned, b1.resp_fault_access}); else passed++;
            total++; if (b1.req_ready !== 1'b0) $display("FAIL load%0d_ready_in_resp: got %b want 0", i, b1.req_ready); else passed++;
        end
    endtask

    task automatic test_stores();
        store_vec_t sv [5];
        sv[0] = '{2'd1, 32'h0000_0102, 32'h1234_ABCD, 1'b0, 4'b1100, 32'hABCD_0000, 4'b0000, 32'h0};
        sv[1] = '{2'd2, 32'h0000_00FE, 32'hAABB_CCDD, 1'b1, 4'b1100, 32'hCCDD_0000, 4'b0011, 32'h0000_AABB};
        sv[2] = '{2'd0, 32'h0000_0101, 32'h0000_00EE, 1'b0, 4'b0010, 32'h0000_EE00, 4'b0000, 32'h0};
        sv[3] = '{2'd2, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'hCAFE_F00D, 4'b0000, 32'h0};
        sv[4] = '{2'd1, 32'h0000_0103, 32'h0000_BEEF, 1'b1, 4'b1000, 32'hEF00_0000, 4'b0001, 32'h0000_00BE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req1(1'b1, sv[i].size, 1'b0, sv[i].addr, sv[i].wdata);
            #1;
            total++; if ({b1.dmem_en, b1.dmem_wen} !== 2'b11) $display("FAIL store%0d_en_wen0: got %b want 11", i, {b1.dmem_en, b1.dmem_wen}); else passed++;
            total++; if (b1.dmem_addr !== (sv[i].addr & 32'hFFFF_FFFC)) $display("FAIL store%0d_addr0: got %h want %h", i, b1.dmem_addr, sv[i].addr & 32'hFFFF_FFFC); else passed++;
            @(negedge clk);
            b1.req_valid  = 1'b0;
            b1.dmem_rdata = 32'hFFFF_FFFF;
            #1;
            total++; if (b1.dmem_wstrb !== sv[i].s0) $display("FAIL store%0d_strb0: got %b want %b", i, b1.dmem_wstrb, sv[i].s0); else passed++;
            total++; if (b1.dmem_wdata !== sv[i].w0) $display("FAIL store%0d_wdata0: got %h want %h", i, b1.dmem_wdata, sv[i].w0); else passed++;
            total++; if (b1.dmem_en !== sv[i].split) $display("FAIL store%0d_en1: got %b want %b", i, b1.dmem_en, sv[i].split); else passed++;
            if (sv[i].split) begin
                total++; if (b1.dmem_wen !== 1'b1) $display("FAIL store%0d_wen1: got %b want 1", i, b1.dmem_wen); else passed++;
                total++; if (b1.dmem_addr !== (sv[i].addr & 32'hFFFF_FFFC) + 32'd4) $display("FAIL store%0d_addr1: got %h want %h", i, b1.dmem_addr, (sv[i].addr & 32'hFFFF_FFFC) + 32'd4); else passed++;
                @(negedge clk);
                #1;
                total++; if (b1.dmem_wstrb !== sv[i].s1) $display("FAIL store%0d_strb1: got %b want %b", i, b1.dmem_wstrb, sv[i].s1); else passed++;
                total++; if (b1.dmem_wdata !== sv[i].w1) $display("FAIL store%0d_wdata1: got %h want %h", i, b1.dmem_wdata, sv[i].w1); else passed++;
            end
            @(negedge clk);
            b1.dmem_rdata = 32'h0;
            #1;
            total++; if (b1.resp_valid !== 1'b1) $display("FAIL store%0d_resp_valid: got %b want 1", i, b1.resp_valid); else passed++;
            total++; if (b1.resp_rdata !== 32'h0) $display("FAIL store%0d_rdata: got %h want 0", i, b1.resp_rdata); else passed++;
            total++; if ({b1.resp_fault_misaligned, b1.resp_fault_access} !== 2'b00) $display("FAIL store%0d_faults: got %b want 00", i, {b1.resp_fault_misaligned, b1.resp_fault_access}); else passed++;
        end
    endtask

    task automatic test_misaligned_fault();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_0101;
        addrs[1] = 32'h0000_0102;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b0.req_valid = 1'b1;
            b0.req_wen   = 1'b0;
            b0.req_size  = (i == 0) ? 2'd1 : 2'd2;
            b0.req_addr  = addrs[i];
            b0.dmem_rdata = 32'h1234_5678;
            #1;
            total++; if (b0.dmem_en !== 1'b0) $display("FAIL misal%0d_no_bus: got %b want 0", i, b0.dmem_en); else passed++;
            @(negedge clk);
            b0.req_valid = 1'b0;
            #1;
            total++; if (b0.resp_valid !== 1'b1) $display("FAIL misal%0d_resp_valid: got %b want 1", i, b0.resp_valid); else passed++;
            total++; if (b0.resp_fault_misaligned !== 1'b1) $display("FAIL misal%0d_fault_mis: got %b want 1", i, b0.resp_fault_misaligned); else passed++;
            total++; if (b0.resp_fault_access !== 1'b0) $display("FAIL misal%0d_fault_acc: got %b want 0", i, b0.resp_fault_access); else passed++;
            total++; if (b0.resp_rdata !== 32'h0) $display("FAIL misal%0d_rdata: got %h want 0", i, b0.resp_rdata); else passed++;
        end
        // Aligned word on the faulting configuration still goes to the bus.
        @(negedge clk);
        b0.req_valid = 1'b1;
        b0.req_size  = 2'd2;
        b0.req_addr  = 32'h0000_0104;
        #1;
        total++; if (b0.dmem_en !== 1'b1 || b0.dmem_addr !== 32'h0000_0104) $display("FAIL aligned0_bus: got en=%b addr=%h want en=1 addr=00000104", b0.dmem_en, b0.dmem_addr); else passed++;
        @(negedge clk);
        b0.req_valid = 1'b0;
        @(negedge clk);
        #1;
        total++; if (b0.resp_valid !== 1'b1 || b0.resp_rdata !== 32'h1234_5678) $display("FAIL aligned0_resp: got v=%b data=%h want v=1 data=12345678", b0.resp_valid, b0.resp_rdata); else passed++;
        b0.dmem_rdata = 32'h0;
    endtask

    task automatic test_illegal_size();
        @(negedge clk);
        req1(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        total++; if (b1.dmem_en !== 1'b0) $display("FAIL illegal_no_bus: got %b want 0", b1.dmem_en); else passed++;
        @(negedge clk);
        b1.req_valid = 1'b0;
        #1;
        total++; if (b1.resp_valid !== 1'b1) $display("FAIL illegal_resp_valid: got %b want 1", b1.resp_valid); else passed++;
        total++; if ({b1.resp_fault_misaligned, b1.resp_fault_access} !== 2'b01) $display("FAIL illegal_faults: got %b want 01", {b1.resp_fault_misaligned, b1.resp_fault_access}); else passed++;
    endtask

    task automatic test_badmem();
        // Error on beat 0 of a split load: beat 1 must not be issued.
        @(negedge clk);
        req1(1'b0, 2'd2, 1'b0, 32'h0000_0103, 32'h0);
        @(negedge clk);
        b1.req_valid     = 1'b0;
        b1.dmem_rdata    = 32'h1122_3344;
        b1.dmem_badmem_e = 1'b1;
        #1;
        total++; if (b1.dmem_en !== 1'b0) $display("FAIL badmem0_no_beat1: got %b want 0", b1.dmem_en); else passed++;
        @(negedge clk);
        b1.dmem_badmem_e = 1'b0;
        #1;
        total++; if (b1.resp_valid !== 1'b1 || b1.resp_fault_access !== 1'b1) $display("FAIL badmem0_resp: got v=%b acc=%b want 1 1", b1.resp_valid, b1.resp_fault_access); else passed++;
        total++; if (b1.resp_rdata !== 32'h0) $display("FAIL badmem0_rdata: got %h want 0", b1.resp_rdata); else passed++;
        // Error on beat 1 of a split load.
        @(negedge clk);
        req1(1'b0, 2'd2, 1'b0, 32'h0000_00FE, 32'h0);
        @(negedge clk);
        b1.req_valid = 1'b0;
        #1;
        total++; if (b1.dmem_en !== 1'b1) $display("FAIL badmem1_beat1: got %b want 1", b1.dmem_en); else passed++;
        @(negedge clk);
        b1.dmem_badmem_e = 1'b1;
        @(negedge clk);
        b1.dmem_badmem_e = 1'b0;
        #1;
        total++; if (b1.resp_valid !== 1'b1 || b1.resp_fault_access !== 1'b1) $display("FAIL badmem1_resp: got v=%b acc=%b want 1 1", b1.resp_valid, b1.resp_fault_access); else passed++;
        total++; if (b1.resp_rdata !== 32'h0) $display("FAIL badmem1_rdata: got %h want 0", b1.resp_rdata); else passed++;
        b1.dmem_rdata = 32'h0;
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        req1(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            b1.req_valid  = 1'b0;
            b1.dmem_wait  = 1'b1;
            b1.dmem_rdata = 32'hBADB_AD00;
            #1;
            total++; if (b1.resp_valid !== 1'b0 || b1.dmem_en !== 1'b0) $display("FAIL wait_c%0d: got v=%b en=%b want 0 0", c, b1.resp_valid, b1.dmem_en); else passed++;
        end
        @(negedge clk);
        b1.dmem_wait  = 1'b0;
        b1.dmem_rdata = 32'h0BAD_F00D;
        #1;
        total++; if (b1.resp_valid !== 1'b0) $display("FAIL wait_c3_resp: got %b want 0", b1.resp_valid); else passed++;
        @(negedge clk);
        b1.dmem_rdata = 32'h0;
        #1;
        total++; if (b1.resp_valid !== 1'b1 || b1.resp_rdata !== 32'h0BAD_F00D) $display("FAIL wait_resp: got v=%b data=%h want v=1 data=0badf00d", b1.resp_valid, b1.resp_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        int seen_resp;
        // req_valid stays high; the second request is taken the cycle after RESP.
        @(negedge clk);
        req1(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        @(negedge clk);
        b1.req_addr   = 32'h0000_0200;
        b1.dmem_rdata = 32'h1111_1111;
        #1;
        total++; if (b1.dmem_en !== 1'b0) $display("FAIL b2b_ignore_d0: got %b want 0", b1.dmem_en); else passed++;
        @(negedge clk);
        #1;
        total++; if (b1.resp_valid !== 1'b1 || b1.resp_rdata !== 32'h1111_1111) $display("FAIL b2b_resp1: got v=%b data=%h want v=1 data=11111111", b1.resp_valid, b1.resp_rdata); else passed++;
        total++; if (b1.dmem_en !== 1'b0 || b1.req_ready !== 1'b0) $display("FAIL b2b_ignore_resp: got en=%b ready=%b want 0 0", b1.dmem_en, b1.req_ready); else passed++;
        @(negedge clk);
        #1;
        total++; if (b1.dmem_en !== 1'b1 || b1.dmem_addr !== 32'h0000_0200) $display("FAIL b2b_accept2: got en=%b addr=%h want en=1 addr=00000200", b1.dmem_en, b1.dmem_addr); else passed++;
        @(negedge clk);
        b1.req_valid  = 1'b0;
        b1.dmem_rdata = 32'h2222_2222;
        @(negedge clk);
        b1.dmem_rdata = 32'h0;
        #1;
        total++; if (b1.resp_valid !== 1'b1 || b1.resp_rdata !== 32'h2222_2222) $display("FAIL b2b_resp2: got v=%b data=%h want v=1 data=22222222", b1.resp_valid, b1.resp_rdata); else passed++;
        seen_resp = 0;
        @(negedge clk);
        #1;
        if (b1.resp_valid) seen_resp++;
        total++; if (seen_resp != 0) $display("FAIL b2b_pulse_width: got %0d extra resp cycles want 0", seen_resp); else passed++;
    endtask

    task automatic test_reset_in_d0();
        int seen_resp;
        @(negedge clk);
        req1(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        @(negedge clk);
        b1.req_valid = 1'b0;
        b1.dmem_wait = 1'b1;
        reset        = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        b1.dmem_wait = 1'b0;
        #1;
        total++; if (b1.req_ready !== 1'b1) $display("FAIL rst_d0_ready: got %b want 1", b1.req_ready); else passed++;
        seen_resp = 0;
        if (b1.resp_valid) seen_resp++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (b1.resp_valid) seen_resp++;
        end
        total++; if (seen_resp != 0) $display("FAIL rst_d0_no_resp: got %0d resp cycles want 0", seen_resp); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        b1.req_valid = 1'b0; b1.req_wen = 1'b0; b1.req_size = 2'd0; b1.req_unsigned = 1'b0;
        b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
        b1.dmem_wait = 1'b0; b1.dmem_rdata = 32'h0; b1.dmem_badmem_e = 1'b0;
        b0.req_valid = 1'b0; b0.req_wen = 1'b0; b0.req_size = 2'd0; b0.req_unsigned = 1'b0;
        b0.req_addr = 32'h0; b0.req_wdata = 32'h0;
        b0.dmem_wait = 1'b0; b0.dmem_rdata = 32'h0; b0.dmem_badmem_e = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_loads();
        test_stores();
        test_misaligned_fault();
        test_illegal_size();
        test_badmem();
        test_wait_states();
        test_back_to_back();
        test_reset_in_d0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
